// File: rtl/eig_mag_rank.sv
// Frame-based ranking of eigenvalue magnitudes: reports max (with index), min,
// beat count, truncation and negative-input flags for each frame.
module eig_mag_rank #(
  parameter int N    = 18,
  parameter int MAXK = 8,
  parameter int IW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*N-1:0]  in_mag,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_max,
  output logic [IW-1:0]   out_max_idx,
  output logic [2*N-1:0]  out_min,
  output logic [IW:0]     out_count,
  output logic            out_ovf,
  output logic            out_neg
);

  localparam int W = 2 * N;
  localparam logic [IW:0] MAXK_C = (IW+1)'(MAXK);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_max_q, acc_max_d;
  logic [W-1:0]   acc_min_q, acc_min_d;
  logic [IW-1:0]  acc_idx_q, acc_idx_d;
  logic [IW:0]    acc_cnt_q, acc_cnt_d;
  logic           acc_neg_q, acc_neg_d;

  logic [W-1:0]   res_max_q;
  logic [W-1:0]   res_min_q;
  logic [IW-1:0]  res_idx_q;
  logic [IW:0]    res_cnt_q;
  logic           res_ovf_q;
  logic           res_neg_q;

  logic           accept;
  logic           beat_neg;
  logic [W-1:0]   beat_val;
  logic [IW:0]    cnt_inc;
  logic           done;
  logic           ovf_d;

  // Negative magnitudes are clamped to zero but remembered via the neg flag.
  assign beat_neg  = in_mag[W-1];
  assign beat_val  = beat_neg ? '0 : in_mag;
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = acc_cnt_q + (IW+1)'(1);

  always_comb begin
    state_d   = state_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    acc_idx_d = acc_idx_q;
    acc_cnt_d = acc_cnt_q;
    acc_neg_d = acc_neg_q;
    done      = 1'b0;
    ovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_max_d = beat_val;
          acc_min_d = beat_val;
          acc_idx_d = '0;
          acc_cnt_d = (IW+1)'(1);
          acc_neg_d = beat_neg;
          done      = in_last;
          state_d   = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Strict compares keep the earliest index on ties.
          if (beat_val > acc_max_q) begin
            acc_max_d = beat_val;
            acc_idx_d = acc_cnt_q[IW-1:0];
          end
          if (beat_val < acc_min_q) begin
            acc_min_d = beat_val;
          end
          acc_cnt_d = cnt_inc;
          acc_neg_d = acc_neg_q | beat_neg;
          if (in_last || (cnt_inc == MAXK_C)) begin
            done    = 1'b1;
            ovf_d   = ~in_last;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers capture the frame only when it terminates, so they stay
  // frozen through HOLD and show the last completed frame otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_max_q <= '0;
      acc_min_q <= '0;
      acc_idx_q <= '0;
      acc_cnt_q <= '0;
      acc_neg_q <= 1'b0;
      res_max_q <= '0;
      res_min_q <= '0;
      res_idx_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
      res_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_max_q <= acc_max_d;
      acc_min_q <= acc_min_d;
      acc_idx_q <= acc_idx_d;
      acc_cnt_q <= acc_cnt_d;
      acc_neg_q <= acc_neg_d;
      if (done) begin
        res_max_q <= acc_max_d;
        res_min_q <= acc_min_d;
        res_idx_q <= acc_idx_d;
        res_cnt_q <= acc_cnt_d;
        res_ovf_q <= ovf_d;
        res_neg_q <= acc_neg_d;
      end
    end
  end

  assign out_max     = res_max_q;
  assign out_min     = res_min_q;
  assign out_max_idx = res_idx_q;
  assign out_count   = res_cnt_q;
  assign out_ovf     = res_ovf_q;
  assign out_neg     = res_neg_q;

endmodule

// File: tb/tb_eig_mag_rank.sv
// Self-checking bench for eig_mag_rank: directed vector table, hand-written
// stall/reset sequences and a randomized run against a frame-level model.
module tb_eig_mag_rank;

  localparam int N    = 18;
  localparam int MAXK = 8;
  localparam int IW   = 3;
  localparam int W    = 2 * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_mag;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_max;
  logic [IW-1:0]  out_max_idx;
  logic [W-1:0]   out_min;
  logic [IW:0]    out_count;
  logic           out_ovf;
  logic           out_neg;

  int errors = 0;
  int checks = 0;

  eig_mag_rank #(.N(N), .MAXK(MAXK), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mag      (in_mag),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_max_idx (out_max_idx),
    .out_min     (out_min),
    .out_count   (out_count),
    .out_ovf     (out_ovf),
    .out_neg     (out_neg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  max;
    logic [IW-1:0] idx;
    logic [W-1:0]  min;
    logic [IW:0]   cnt;
    logic          ovf;
    logic          neg;
  } res_t;

  typedef struct packed {
    logic [W-1:0] mag;
    logic         last;
    logic         hasRes;
    res_t         exp;
  } vec_t;

  vec_t vecs[$];
  res_t expQ[$];
  logic [W-1:0] frameQ[$];
  logic [W-1:0] rndMag[$];
  logic         rndLast[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic checkRes(input string tag, input res_t e);
    checkOutput({tag, "_max"}, 64'(out_max), 64'(e.max));
    checkOutput({tag, "_idx"}, 64'(out_max_idx), 64'(e.idx));
    checkOutput({tag, "_min"}, 64'(out_min), 64'(e.min));
    checkOutput({tag, "_cnt"}, 64'(out_count), 64'(e.cnt));
    checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
    checkOutput({tag, "_neg"}, 64'(out_neg), 64'(e.neg));
  endtask

  function automatic res_t mkRes(input int mx, input int ix, input int mn, input int cn,
                                 input bit ov, input bit ng);
    res_t r;
    r.max = W'(mx);
    r.idx = IW'(ix);
    r.min = W'(mn);
    r.cnt = (IW+1)'(cn);
    r.ovf = ov;
    r.neg = ng;
    return r;
  endfunction

  function automatic vec_t mkVec(input logic [W-1:0] m, input bit l, input bit h, input res_t e);
    vec_t v;
    v.mag = m;
    v.last = l;
    v.hasRes = h;
    v.exp = e;
    return v;
  endfunction

  // Frame-level reference: clamp, then plain max/min search over the frame.
  function automatic res_t modelFrame(input bit lastSeen);
    res_t r;
    logic [W-1:0] v;
    r = '0;
    for (int i = 0; i < frameQ.size(); i++) begin
      v = frameQ[i][W-1] ? '0 : frameQ[i];
      if (frameQ[i][W-1]) r.neg = 1'b1;
      if (i == 0 || v > r.max) begin
        r.max = v;
        r.idx = IW'(i);
      end
      if (i == 0 || v < r.min) r.min = v;
    end
    r.cnt = (IW+1)'(frameQ.size());
    r.ovf = (frameQ.size() == MAXK) && !lastSeen;
    return r;
  endfunction

  // Presents one beat and waits (bounded) until the block takes it.
  task automatic applyStimulus(input logic [W-1:0] m, input bit l);
    bit taken = 0;
    in_valid = 1'b1;
    in_mag   = m;
    in_last  = l;
    for (int c = 0; c < 50 && !taken; c++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic expectResult(input string tag, input res_t e);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkRes(tag, e);
    checkOutput({tag, "_bubble"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] neg3;
    int bi, cyc;
    bit pending, lastAccepted;
    res_t e;

    neg3 = 36'hF_FFFF_FFFD;
    rst = 1'b1;
    in_valid = 1'b0;
    in_mag = '0;
    in_last = 1'b0;
    out_ready = 1'b1;

    #3;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkRes("rst", mkRes(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs.push_back(mkVec(W'(40),  0, 0, '0));
    vecs.push_back(mkVec(W'(100), 0, 0, '0));
    vecs.push_back(mkVec(W'(7),   0, 0, '0));
    vecs.push_back(mkVec(W'(100), 1, 1, mkRes(100, 1, 7, 4, 0, 0)));
    vecs.push_back(mkVec(W'(55),  1, 1, mkRes(55, 0, 55, 1, 0, 0)));
    for (int k = 1; k <= 7; k++) vecs.push_back(mkVec(W'(k), 0, 0, '0));
    vecs.push_back(mkVec(W'(8), 0, 1, mkRes(8, 7, 1, 8, 1, 0)));
    vecs.push_back(mkVec(W'(9), 1, 1, mkRes(9, 0, 9, 1, 0, 0)));
    vecs.push_back(mkVec(neg3,  0, 0, '0));
    vecs.push_back(mkVec(W'(20), 1, 1, mkRes(20, 1, 0, 2, 0, 1)));
    vecs.push_back(mkVec(W'(5), 0, 0, '0));
    vecs.push_back(mkVec(W'(9), 0, 0, '0));
    vecs.push_back(mkVec(W'(9), 0, 0, '0));
    vecs.push_back(mkVec(W'(2), 0, 0, '0));
    vecs.push_back(mkVec(W'(2), 1, 1, mkRes(9, 1, 2, 5, 0, 0)));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].mag, vecs[i].last);
      if (vecs[i].hasRes) expectResult($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Consumer stalls for five cycles while the result is held.
    out_ready = 1'b0;
    applyStimulus(W'(3), 0);
    applyStimulus(W'(8), 0);
    applyStimulus(W'(1), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_ready", 64'(in_ready), 64'd0);
      checkRes("stall", mkRes(8, 1, 1, 3, 0, 0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hs_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_hs_ready", 64'(in_ready), 64'd1);
    checkOutput("post_hs_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame and the previous result.
    applyStimulus(W'(11), 0);
    applyStimulus(W'(22), 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_ready", 64'(in_ready), 64'd1);
    checkRes("midrst", mkRes(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("midrst_novalid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(W'(5), 0);
    applyStimulus(W'(9), 1);
    expectResult("afterrst", mkRes(9, 1, 5, 2, 0, 0));

    // Randomized traffic with random valid/ready against the frame model.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 7))
        0:       rndMag.push_back({1'b1, 35'($urandom)});
        1:       rndMag.push_back({1'b0, 35'($urandom)});
        default: rndMag.push_back(W'($urandom_range(0, 15)));
      endcase
      rndLast.push_back(k == 299 || $urandom_range(0, 3) == 0);
    end
    bi = 0;
    cyc = 0;
    pending = 0;
    frameQ.delete();
    expQ.delete();
    while ((bi < rndMag.size() || pending) && cyc < 20000) begin
      in_valid  = (bi < rndMag.size()) && ($urandom_range(0, 3) != 0);
      in_mag    = (bi < rndMag.size()) ? rndMag[bi] : '0;
      in_last   = (bi < rndMag.size()) ? rndLast[bi] : 1'b0;
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      checkOutput("rnd_ready", 64'(in_ready), 64'(!pending));
      checkOutput("rnd_valid", 64'(out_valid), 64'(pending));
      if (pending) begin
        checkRes("rnd", expQ[0]);
        if (out_ready) begin
          void'(expQ.pop_front());
          pending = 0;
        end
      end else if (in_valid) begin
        frameQ.push_back(in_mag);
        lastAccepted = in_last;
        bi++;
        if (lastAccepted || frameQ.size() == MAXK) begin
          e = modelFrame(lastAccepted);
          expQ.push_back(e);
          frameQ.delete();
          pending = 1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 20000) checkOutput("rnd_timeout", 64'd0, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eig_mag_rank.md
EIG_MAG_RANK -- requirements
Module: eig_mag_rank

Interface
REQ-001 Parameter N, default 18: half magnitude width; magnitudes are 2*N bits, matching the upstream magnitude stage output.
REQ-002 Parameter MAXK, default 8: maximum eigenvalue magnitudes per frame, range 2..256.
REQ-003 Parameter IW, default 3: index width, equal to ceil(log2(MAXK)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_mag/in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_mag  input  2*N  signed magnitude from the upstream magnitude stage.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 out_valid  output  1  frame result is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_max  output  2*N  largest magnitude in the frame (spectral radius estimate).
REQ-013 out_max_idx  output  IW  zero-based beat index of out_max.
REQ-014 out_min  output  2*N  smallest magnitude in the frame.
REQ-015 out_count  output  IW+1  number of beats in the frame.
REQ-016 out_ovf  output  1  frame was truncated at MAXK beats.
REQ-017 out_neg  output  1  at least one beat in the frame had a negative in_mag.

Function
REQ-018 A beat is accepted when in_valid and in_ready are both 1 on a rising clk edge; no other condition accepts a beat.
REQ-019 The FSM shall have exactly three states: IDLE, ACCUM and HOLD.
REQ-020 in_ready shall be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-021 out_valid shall be 1 only in HOLD.
REQ-022 All result outputs shall be registered and held stable throughout HOLD.
REQ-023 Input clamp: a beat with in_mag MSB = 1 shall be used as value 0 and shall set the frame neg flag.
REQ-024 IDLE, on accept:
- max = min = the clamped value
- max_idx = 0, count = 1
- neg flag and ovf flag cleared, then updated from this beat
- next state is HOLD if in_last = 1, else ACCUM
REQ-025 ACCUM, on accept:
- max is replaced only if value > max (strictly greater); max_idx = count
- on ties max_idx keeps the earlier index
- min is replaced only if value < min (strictly less)
- count increments
REQ-026 ACCUM exit: on accept with in_last = 1, or with count reaching MAXK after the increment, the next state is HOLD.
REQ-027 Overflow: when a frame reaches MAXK beats and the MAXK-th beat has in_last = 0, out_ovf = 1.
REQ-028 After an overflow, beats accepted after the HOLD handshake start a new frame; no beats are discarded.
REQ-029 Comparisons are unsigned on the clamped 2*N-bit value; no arithmetic widening is needed.
REQ-030 Latency: out_valid rises in the cycle after the terminating beat is accepted.
REQ-031 HOLD to IDLE occurs on out_valid and out_ready both 1; in_ready is 1 in the following cycle.
REQ-032 There is a minimum one-cycle bubble between frames; no input beat is accepted in the handshake cycle.
REQ-033 A single-beat frame (in_last = 1 on the first beat) shall give out_max = out_min = value, out_max_idx = 0, out_count = 1.
REQ-034 In IDLE and ACCUM, the result outputs show the last completed frame and are don't-care to the consumer.

Reset
REQ-035 On rst = 1 the block shall enter IDLE asynchronously.
REQ-036 On rst = 1 the following outputs shall be driven to 0:
- out_valid, out_max, out_max_idx, out_min, out_count, out_ovf, out_neg
- in_ready shall read 1 once the block is in IDLE
REQ-037 Reset asserted mid-frame or in HOLD shall discard the partial or held result, with no out_valid pulse.
REQ-038 The first accepted beat after rst deasserts starts a new frame.

Verification
REQ-039 Frame {40, 100, 7, 100(last)}, out_ready = 1 -> out_max = 100, out_max_idx = 1, out_min = 7, out_count = 4, out_ovf = 0, out_neg = 0; out_valid one cycle after the last beat.
REQ-040 Single beat 55 with in_last = 1 -> out_max = out_min = 55, idx = 0, count = 1.
REQ-041 MAXK = 8, nine beats 1..9, last only on the 9th beat:
- first result: out_max = 8, idx = 7, out_min = 1, count = 8, out_ovf = 1
- second result: out_max = out_min = 9, count = 1
REQ-042 Beat value -3 in frame {-3, 20(last)} -> out_min = 0, out_max = 20, out_neg = 1.
REQ-043 Hold out_ready = 0 for 5 cycles in HOLD -> out_valid and all results stable, in_ready = 0; in_ready = 1 the cycle after out_ready rises.
REQ-044 Assert rst after 2 beats of a frame -> all outputs 0 immediately, no out_valid; the next frame {5, 9(last)} gives max = 9, min = 5, count = 2.
